// File: rtl/adc_frame_ingress.sv
// adc_frame_ingress: multi-channel ADC capture with a beat FIFO and frame markers.
// Each accepted strobe becomes one beat; beats are grouped into FRAME_LEN-beat
// frames (tuser on the first beat, tlast on the last). Strobes that arrive while
// the FIFO is full are dropped and counted.
module adc_frame_ingress #(
  parameter int NUM_CH    = 2,
  parameter int ADC_W     = 16,
  parameter int DEPTH     = 8,
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [NUM_CH*ADC_W-1:0]   adc_data,
  input  logic                      adc_valid,
  output logic [NUM_CH*ADC_W-1:0]   m_tdata,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic                      m_tlast,
  output logic                      m_tuser,
  output logic [CNT_W-1:0]          overflow_cnt,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic                      busy
);

  localparam int DW = NUM_CH * ADC_W;
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST_BEAT = CW'(FRAME_LEN - 1);
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_beat, w_beat_nxt;
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr, w_rd_ptr_nxt;
  logic [LW-1:0]   r_level, w_level_nxt;
  logic [CNT_W-1:0] r_ovf;
  logic [DW-1:0]   r_mem_data [DEPTH];
  logic            r_mem_last [DEPTH];
  logic            r_mem_user [DEPTH];
  logic [DW-1:0]   r_tdata;
  logic            r_tlast, r_tuser;
  logic            w_busy, w_attempt, w_push, w_drop, w_pop;
  logic            w_new_last, w_new_user, w_head_is_new;

  // Overflow counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Capture FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Capture FSM next state: leaving RUN or FINISH only on a frame boundary,
  // judged on the beat count after this cycle's acceptance so no frame is cut short.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (enable) w_state_nxt = S_RUN;
      S_RUN:    if (!enable) w_state_nxt = (w_beat_nxt == '0) ? S_IDLE : S_FINISH;
      S_FINISH: begin
        if (enable)                 w_state_nxt = S_RUN;
        else if (w_beat_nxt == '0)  w_state_nxt = S_IDLE;
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Capture FSM outputs.
  always_comb begin
    w_busy = (r_state != S_IDLE);
  end

  // Acceptance, drop, pop decisions and next FIFO/frame bookkeeping values.
  always_comb begin
    w_attempt  = adc_valid && w_busy;
    w_push     = w_attempt && (r_level < FULL_LVL);
    w_drop     = w_attempt && (r_level == FULL_LVL);
    w_pop      = (r_level != '0) && m_tready;
    w_new_user = (r_beat == '0);
    w_new_last = (r_beat == LAST_BEAT);
    w_beat_nxt = r_beat;
    if (w_push) w_beat_nxt = w_new_last ? '0 : r_beat + CW'(1);
    w_rd_ptr_nxt  = r_rd_ptr + PW'(w_pop);
    w_level_nxt   = r_level + LW'(w_push) - LW'(w_pop);
    // The entry becoming head is the one written this cycle when the FIFO drains to it.
    w_head_is_new = w_push && (r_wr_ptr == w_rd_ptr_nxt);
  end

  // FIFO pointers, occupancy, frame beat counter and drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_beat   <= '0;
      r_ovf    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      r_rd_ptr <= w_rd_ptr_nxt;
      r_level  <= w_level_nxt;
      r_beat   <= w_beat_nxt;
      if (w_drop) r_ovf <= sat_inc(r_ovf);
    end
  end

  // FIFO storage: data and frame markers kept together per entry.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= adc_data;
      r_mem_last[r_wr_ptr] <= w_new_last;
      r_mem_user[r_wr_ptr] <= w_new_user;
    end
  end

  // Registered head entry; holds its last value while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tdata <= '0;
      r_tlast <= 1'b0;
      r_tuser <= 1'b0;
    end else if (w_level_nxt != '0) begin
      if (w_head_is_new) begin
        r_tdata <= adc_data;
        r_tlast <= w_new_last;
        r_tuser <= w_new_user;
      end else begin
        r_tdata <= r_mem_data[w_rd_ptr_nxt];
        r_tlast <= r_mem_last[w_rd_ptr_nxt];
        r_tuser <= r_mem_user[w_rd_ptr_nxt];
      end
    end
  end

  assign m_tdata      = r_tdata;
  assign m_tlast      = r_tlast;
  assign m_tuser      = r_tuser;
  assign m_tvalid     = (r_level != '0);
  assign fifo_level   = r_level;
  assign overflow_cnt = r_ovf;
  assign busy         = w_busy;

endmodule

// File: tb/tb_adc_frame_ingress.sv
// Bench for adc_frame_ingress: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_adc_frame_ingress;
  localparam int NUM_CH = 2, ADC_W = 16, DEPTH = 8, FRAME_LEN = 4;
  localparam int DW = NUM_CH * ADC_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, enable = 1'b0, adc_valid = 1'b0, m_tready = 1'b0;
  logic [DW-1:0] adc_data = '0;
  logic [DW-1:0] m_tdata, u_tdata;
  logic m_tvalid, m_tlast, m_tuser, busy, u_tvalid, u_tlast, u_tuser, u_busy;
  logic [15:0] overflow_cnt;
  logic [3:0]  u_ovf;
  logic [3:0]  fifo_level, u_level;

  adc_frame_ingress #(.NUM_CH(NUM_CH), .ADC_W(ADC_W), .DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .adc_data(adc_data), .adc_valid(adc_valid),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .m_tuser(m_tuser), .overflow_cnt(overflow_cnt), .fifo_level(fifo_level), .busy(busy));

  adc_frame_ingress #(.NUM_CH(NUM_CH), .ADC_W(ADC_W), .DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .enable(enable), .adc_data(adc_data), .adc_valid(adc_valid),
    .m_tdata(u_tdata), .m_tvalid(u_tvalid), .m_tready(m_tready), .m_tlast(u_tlast),
    .m_tuser(u_tuser), .overflow_cnt(u_ovf), .fifo_level(u_level), .busy(u_busy));

  int total = 0, bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: FIFO as a queue, frame position as an integer.
  typedef struct { logic [DW-1:0] d; logic l; logic u; } beat_t;
  beat_t q[$];
  beat_t mhead = '{'0, 1'b0, 1'b0};
  int ms = 0;     // 0 idle, 1 run, 2 finish
  int mcnt = 0, movf = 0, movf4 = 0;

  task automatic model_step();
    bit attempt, full, pop;
    if (rst) begin
      q.delete(); ms = 0; mcnt = 0; movf = 0; movf4 = 0;
      mhead = '{'0, 1'b0, 1'b0};
    end else begin
      attempt = adc_valid && (ms != 0);
      full    = (q.size() == DEPTH);
      pop     = (q.size() != 0) && m_tready;
      if (pop) void'(q.pop_front());
      if (attempt && !full) begin
        q.push_back('{adc_data, (mcnt == FRAME_LEN - 1), (mcnt == 0)});
        mcnt = (mcnt + 1) % FRAME_LEN;
      end
      if (attempt && full) begin
        if (movf < 65535) movf++;
        if (movf4 < 15) movf4++;
      end
      case (ms)
        0: if (enable) ms = 1;
        1: if (!enable) ms = (mcnt == 0) ? 0 : 2;
        default: if (enable) ms = 1; else if (mcnt == 0) ms = 0;
      endcase
      if (q.size() > 0) mhead = q[0];
    end
  endtask

  task automatic check_model();
    check("model.tvalid", m_tvalid, q.size() > 0);
    check("model.tdata", m_tdata, mhead.d);
    check("model.tlast", m_tlast, mhead.l);
    check("model.tuser", m_tuser, mhead.u);
    check("model.level", fifo_level, q.size());
    check("model.ovf", overflow_cnt, movf);
    check("model.ovf4", u_ovf, movf4);
    check("model.busy", busy, ms != 0);
  endtask

  task automatic tick(input logic r, input logic e, input logic v, input logic rdy, input logic [DW-1:0] d);
    rst = r; enable = e; adc_valid = v; m_tready = rdy; adc_data = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  typedef struct {
    logic r, e, v, rdy; logic [DW-1:0] d;
    logic tv; logic [DW-1:0] td; logic tl, tu; int lvl; int ovf; logic bsy;
  } vec_t;
  vec_t tbl[9];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 0, 0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_AAAA, 1'b0, 32'h0,         1'b0, 1'b0, 0, 0, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0001_0000, 1'b1, 32'h0001_0000, 1'b0, 1'b1, 1, 0, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0003_0002, 1'b1, 32'h0003_0002, 1'b0, 1'b0, 1, 0, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0005_0004, 1'b1, 32'h0005_0004, 1'b0, 1'b0, 1, 0, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0007_0006, 1'b1, 32'h0007_0006, 1'b1, 1'b0, 1, 0, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0007_0006, 1'b1, 1'b0, 0, 0, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0007_0006, 1'b1, 1'b0, 0, 0, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_1234, 1'b0, 32'h0007_0006, 1'b1, 1'b0, 0, 0, 1'b0};

    @(negedge clk);
    // Reset and basic frame from the vector table.
    for (int i = 0; i < 9; i++) begin
      tick(tbl[i].r, tbl[i].e, tbl[i].v, tbl[i].rdy, tbl[i].d);
      check($sformatf("vec%0d.tvalid", i), m_tvalid, tbl[i].tv);
      check($sformatf("vec%0d.tdata", i), m_tdata, tbl[i].td);
      check($sformatf("vec%0d.tlast", i), m_tlast, tbl[i].tl);
      check($sformatf("vec%0d.tuser", i), m_tuser, tbl[i].tu);
      check($sformatf("vec%0d.level", i), fifo_level, tbl[i].lvl);
      check($sformatf("vec%0d.ovf", i), overflow_cnt, tbl[i].ovf);
      check($sformatf("vec%0d.busy", i), busy, tbl[i].bsy);
    end

    // Backpressure and overflow, then drain in order.
    tick(0, 1, 0, 0, 0); check_model();
    for (int i = 0; i < 10; i++) begin
      tick(0, 1, 1, 0, 32'h100 + i); check_model();
      check("stall.tdata", m_tdata, 32'h100);
    end
    check("bp.level", fifo_level, 8);
    check("bp.ovf", overflow_cnt, 2);
    for (int k = 0; k < 8; k++) begin
      check("drain.tdata", m_tdata, 32'h100 + k);
      check("drain.tlast", m_tlast, (k == 3 || k == 7));
      tick(0, 1, 0, 1, 0); check_model();
    end
    check("drain.level", fifo_level, 0);

    // Frame-aligned stop through FINISH.
    tick(0, 1, 1, 1, 32'h200); check_model();
    tick(0, 1, 1, 1, 32'h201); check_model();
    tick(0, 0, 0, 1, 0); check_model();
    check("finish.busy", busy, 1);
    tick(0, 0, 1, 1, 32'h202); check_model();
    tick(0, 0, 1, 1, 32'h203); check_model();
    check("finish.idle", busy, 0);
    check("finish.tlast", m_tlast, 1);
    check("finish.tdata", m_tdata, 32'h203);
    tick(0, 0, 1, 1, 32'h204); check_model();
    check("idle.ovf", overflow_cnt, 2);
    check("idle.level", fifo_level, 0);

    // Full FIFO with a simultaneous pop: strobe still dropped.
    tick(0, 1, 0, 0, 0); check_model();
    for (int i = 0; i < 8; i++) begin
      tick(0, 1, 1, 0, 32'h300 + i); check_model();
    end
    check("fullpop.pre", fifo_level, 8);
    tick(0, 1, 1, 1, 32'h3FF); check_model();
    check("fullpop.level", fifo_level, 7);
    check("fullpop.ovf", overflow_cnt, 3);
    check("fullpop.tdata", m_tdata, 32'h301);

    // Reset in the middle of a frame.
    for (int i = 0; i < 7; i++) begin
      tick(0, 1, 0, 1, 0); check_model();
    end
    tick(0, 1, 1, 0, 32'h400); check_model();
    tick(0, 1, 1, 0, 32'h401); check_model();
    tick(1, 1, 0, 0, 0);
    check("rst.tvalid", m_tvalid, 0);
    check("rst.tdata", m_tdata, 0);
    check("rst.tlast", m_tlast, 0);
    check("rst.tuser", m_tuser, 0);
    check("rst.level", fifo_level, 0);
    check("rst.ovf", overflow_cnt, 0);
    check("rst.busy", busy, 0);
    tick(0, 1, 0, 0, 0); check_model();
    tick(0, 1, 1, 0, 32'h500); check_model();
    check("rst.sof", m_tuser, 1);
    check("rst.first", m_tdata, 32'h500);

    // Saturation of the narrow counter.
    for (int i = 0; i < 27; i++) begin
      tick(0, 1, 1, 0, 32'h600 + i); check_model();
    end
    check("sat.ovf4", u_ovf, 15);
    check("sat.ovf16", overflow_cnt, 20);

    // Randomized run against the model.
    tick(1, 0, 0, 0, 0); check_model();
    for (int i = 0; i < 3000; i++) begin
      logic r, e, v, rdy;
      r   = ($urandom_range(0, 499) == 0);
      e   = ($urandom_range(0, 9) < ((i % 600 < 300) ? 9 : 5));
      v   = ($urandom_range(0, 9) < 6);
      rdy = ($urandom_range(0, 99) < ((i % 1000 < 500) ? 30 : 80));
      tick(r, e, v, rdy, $urandom); check_model();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
